// File: rtl/stage2_if.sv
// Stage-2 game bus: start/jump inputs and result outputs to stage3.
// master drives game inputs; slave is the stage2 block.
interface stage2_if;
    logic       start;
    logic       pass1;
    logic       jump_vld;
    logic [2:0] jump;
    logic       busy;
    logic       done;
    logic       pass2;
    logic [1:0] bonus2;
    logic [2:0] luck3;

    modport master (
        output start, pass1, jump_vld, jump,
        input  busy, done, pass2, bonus2, luck3
    );

    modport slave (
        input  start, pass1, jump_vld, jump,
        output busy, done, pass2, bonus2, luck3
    );
endinterface

// File: rtl/stage2.sv
// Stage-2 obstacle game: LFSR obstacles, jump scoring, pass/bonus/luck judge.
// Optional round timeout enabled by macro STAGE2_TIMEOUT_EN.
module stage2 #(
    parameter int ROUNDS   = 8,
    parameter int MAX_MISS = 2,
    parameter int TIMEOUT  = 4
) (
    input logic     clk,
    input logic     rst_n,
    stage2_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PLAY, JUDGE, DONE} state_t;

    state_t     state, nstate;
    logic [2:0] lfsr;
    logic [3:0] rnd;
    logic [3:0] miss;
    logic [3:0] perf;
    logic       p1;
    logic       tmo;
    logic       rnd_end;
    logic       last;
    logic       hit;
    logic       exact;
    logic       miss_ev;
    logic       perf_ev;

`ifdef STAGE2_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] timer;
    assign tmo = (timer == TW'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    assign hit     = (bus.jump >= lfsr);
    assign exact   = (bus.jump == lfsr);
    // a qualified jump wins over a timeout landing on the same cycle
    assign miss_ev = bus.jump_vld ? !hit : tmo;
    assign perf_ev = bus.jump_vld && exact;
    assign rnd_end = (state == PLAY) && (bus.jump_vld || tmo);
    assign last    = (rnd == 4'(ROUNDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (bus.start) nstate = bus.pass1 ? PLAY : JUDGE;
            PLAY:    if (rnd_end && last) nstate = JUDGE;
            JUDGE:   nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == PLAY) || (state == JUDGE);
        bus.done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= 3'b001;
            rnd        <= '0;
            miss       <= '0;
            perf       <= '0;
            p1         <= 1'b0;
            bus.pass2  <= 1'b0;
            bus.bonus2 <= '0;
            bus.luck3  <= '0;
`ifdef STAGE2_TIMEOUT_EN
            timer      <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    lfsr  <= 3'b001;
                    rnd   <= '0;
                    miss  <= '0;
                    perf  <= '0;
                    p1    <= bus.pass1;
`ifdef STAGE2_TIMEOUT_EN
                    timer <= '0;
`endif
                end
                PLAY: if (rnd_end) begin
                    lfsr <= {lfsr[1:0], lfsr[2] ^ lfsr[1]};
                    rnd  <= rnd + 4'd1;
                    if (miss_ev && miss != 4'hf) miss <= miss + 4'd1;
                    if (perf_ev && perf != 4'hf) perf <= perf + 4'd1;
`ifdef STAGE2_TIMEOUT_EN
                    timer <= '0;
                end else begin
                    timer <= timer + TW'(1);
`endif
                end
                JUDGE: begin
                    bus.pass2  <= p1 && (32'(miss) <= 32'(MAX_MISS));
                    bus.bonus2 <= (perf > 4'd3) ? 2'd3 : perf[1:0];
                    bus.luck3  <= lfsr ^ perf[2:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stage2.sv
// Self-checking bench for stage2: vector table, scoreboard queue,
// hand sequences for latency, ignore, reset and timeout behaviour.
module tb_stage2;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    stage2_if bus ();

    stage2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic             p1;
        logic [0:7][2:0]  j;
        logic             p2;
        logic [1:0]       b2;
        logic [2:0]       l3;
    } vec_t;

    typedef struct {
        logic       p2;
        logic [1:0] b2;
        logic [2:0] l3;
    } exp_t;

    vec_t tbl [9];
    exp_t sbq [$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic p1, input logic [0:7][2:0] j,
                                input logic p2, input logic [1:0] b2,
                                input logic [2:0] l3);
        vec_t v;
        v.p1 = p1;
        v.j  = j;
        v.p2 = p2;
        v.b2 = b2;
        v.l3 = l3;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle_cycle();
        bus.jump_vld = 1'b0;
        bus.jump     = 3'($urandom_range(0, 7));
        @(negedge clk);
    endtask

    task automatic start_game(input vec_t v);
        exp_t e;
        e.p2 = v.p2;
        e.b2 = v.b2;
        e.l3 = v.l3;
        sbq.push_back(e);
        bus.start = 1'b1;
        bus.pass1 = v.p1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.pass1 = 1'($urandom_range(0, 1));
        chk("busy_after_start", bus.busy, 1);
    endtask

    task automatic play_rounds(input vec_t v, input int n);
        int gmax;
`ifdef STAGE2_TIMEOUT_EN
        gmax = 3;
`else
        gmax = 4;
`endif
        for (int r = 0; r < n; r++) begin
            int g = $urandom_range(0, gmax);
            for (int k = 0; k < g; k++) idle_cycle();
            bus.jump_vld = 1'b1;
            bus.jump     = v.j[r];
            @(negedge clk);
            bus.jump_vld = 1'b0;
        end
    endtask

    task automatic compare_out(input string nm);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: done with empty scoreboard", nm);
        end else begin
            e = sbq.pop_front();
            chk({nm, "_pass2"}, bus.pass2, e.p2);
            chk({nm, "_bonus2"}, bus.bonus2, e.b2);
            chk({nm, "_luck3"}, bus.luck3, e.l3);
        end
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (bus.done !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: no done within 12 cycles", nm);
        end else begin
            compare_out(nm);
            @(negedge clk);
            chk({nm, "_done_pulse"}, bus.done, 0);
        end
    endtask

    task automatic run_vec(input int i);
        start_game(tbl[i]);
        if (tbl[i].p1) play_rounds(tbl[i], 8);
        wait_done($sformatf("vec%0d", i));
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.pass1    = 1'b0;
        bus.jump_vld = 1'b0;
        bus.jump     = 3'd0;
        rst_n        = 1'b0;

        // obstacles per round from reset seed: 1,2,5,3,7,6,4,1
        tbl[0] = mk(0, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}, 0, 0, 3'b001);
        tbl[1] = mk(1, {3'd1,3'd2,3'd5,3'd3,3'd7,3'd6,3'd4,3'd1}, 1, 3, 3'b010);
        tbl[2] = mk(1, {3'd7,3'd7,3'd7,3'd7,3'd7,3'd7,3'd7,3'd7}, 1, 1, 3'b011);
        tbl[3] = mk(1, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}, 0, 0, 3'b010);
        tbl[4] = mk(1, {3'd1,3'd2,3'd5,3'd3,3'd0,3'd0,3'd0,3'd7}, 0, 3, 3'b110);
        tbl[5] = mk(1, {3'd1,3'd2,3'd5,3'd3,3'd0,3'd0,3'd7,3'd7}, 1, 3, 3'b110);
        tbl[6] = mk(1, {3'd7,3'd7,3'd7,3'd7,3'd7,3'd7,3'd7,3'd1}, 1, 2, 3'b000);
        tbl[7] = mk(1, {3'd0,3'd1,3'd4,3'd2,3'd6,3'd5,3'd3,3'd0}, 0, 0, 3'b010);
        tbl[8] = mk(1, {3'd2,3'd2,3'd5,3'd3,3'd7,3'd6,3'd4,3'd1}, 1, 3, 3'b101);

        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pass2", bus.pass2, 0);
        chk("rst_bonus2", bus.bonus2, 0);
        chk("rst_luck3", bus.luck3, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(i);

        // pass1=0: JUDGE right after start, done the cycle after
        start_game(tbl[0]);
        chk("p0_done_early", bus.done, 0);
        @(negedge clk);
        chk("p0_done_lat", bus.done, 1);
        wait_done("p0_seq");

`ifdef STAGE2_TIMEOUT_EN
        begin
            exp_t e;
            int   n = 0;
            e.p2 = 1'b0;
            e.b2 = 2'd0;
            e.l3 = 3'b010;
            sbq.push_back(e);
            bus.start = 1'b1;
            bus.pass1 = 1'b1;
            while (bus.done !== 1'b1 && n < 60) begin
                @(negedge clk);
                bus.start = 1'b0;
                n++;
            end
            chk("tmo_latency", n, 34);
            if (bus.done === 1'b1) compare_out("tmo");
            @(negedge clk);
        end
`else
        begin
            int seen = 0;
            start_game(tbl[1]);
            for (int k = 0; k < 20; k++) begin
                idle_cycle();
                if (bus.done === 1'b1) seen++;
            end
            chk("notmo_busy", bus.busy, 1);
            chk("notmo_no_done", seen, 0);
            play_rounds(tbl[1], 8);
            wait_done("notmo");
        end
`endif

        // start/jump_vld during JUDGE and DONE are ignored
        start_game(tbl[1]);
        play_rounds(tbl[1], 8);
        chk("ign_judge_busy", bus.busy, 1);
        bus.start    = 1'b1;
        bus.pass1    = 1'b1;
        bus.jump_vld = 1'b1;
        bus.jump     = 3'd7;
        @(negedge clk);
        chk("ign_done", bus.done, 1);
        compare_out("ign");
        @(negedge clk);
        bus.start    = 1'b0;
        bus.jump_vld = 1'b0;
        chk("ign_idle_busy", bus.busy, 0);
        @(negedge clk);
        chk("ign_busy_hold", bus.busy, 0);
        chk("ign_pass2_hold", bus.pass2, 1);
        chk("ign_bonus2_hold", bus.bonus2, 3);
        chk("ign_luck3_hold", bus.luck3, 3'b010);

        // reset in round 3 abandons the game
        start_game(tbl[1]);
        play_rounds(tbl[1], 2);
        idle_cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_pass2", bus.pass2, 0);
        chk("mid_rst_bonus2", bus.bonus2, 0);
        chk("mid_rst_luck3", bus.luck3, 0);
        sbq.delete();
        begin
            int seen = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (bus.done === 1'b1) seen++;
            end
            rst_n = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (bus.done === 1'b1) seen++;
            end
            chk("mid_rst_no_done", seen, 0);
        end
        run_vec(1);
        run_vec(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
